// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie-breaking in the arbiter.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_MASK_BUS = 8;
  localparam int REG_DATA_BUS = 32;

  localparam logic [MEM_ADDR_BUS-1:0] ZERO_ADDR = '0;
  localparam logic [REG_DATA_BUS-1:0] ZERO_WORD = '0;
  localparam logic [MEM_MASK_BUS-1:0] ZERO_MASK = '0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IFU = 1'b0,
    ARB_OWNER_LSU = 1'b1
  } arb_owner_e;

  // Timeout counter saturates at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between IFU and LSU requests.
// With ARB_ROUND_ROBIN_EN a tie goes to the requester that did not own the port last.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_e last_owner,
`endif
  output logic       any_req,
  output arb_owner_e winner
);

  always_comb begin
    any_req = ifu_req | lsu_req;
    winner  = ARB_OWNER_IFU;
    if (ifu_req && lsu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_owner == ARB_OWNER_LSU) ? ARB_OWNER_IFU : ARB_OWNER_LSU;
`else
      winner = ARB_OWNER_LSU;
`endif
    end else if (lsu_req) begin
      winner = ARB_OWNER_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU, one outstanding transaction at a time.
// Build option ARB_ROUND_ROBIN_EN enables round-robin tie-breaking (default: LSU over IFU).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_i,
  input  logic [MEM_ADDR_BUS-1:0] ifu_addr_i,
  output logic                    ifu_gnt_o,
  output logic                    ifu_rvalid_o,
  output logic [REG_DATA_BUS-1:0] ifu_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [MEM_ADDR_BUS-1:0] lsu_addr_i,
  input  logic [REG_DATA_BUS-1:0] lsu_wdata_i,
  input  logic [MEM_MASK_BUS-1:0] lsu_wmask_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [REG_DATA_BUS-1:0] lsu_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic                    mem_we_o,
  output logic [MEM_ADDR_BUS-1:0] mem_addr_o,
  output logic [REG_DATA_BUS-1:0] mem_wdata_o,
  output logic [MEM_MASK_BUS-1:0] mem_wmask_o,
  input  logic                    mem_rvalid_i,
  input  logic [REG_DATA_BUS-1:0] mem_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(RESP_TIMEOUT);

  arb_state_e              state, next_state;
  arb_owner_e              owner, winner;
  logic                    any_req;
  logic                    lat_we;
  logic [MEM_ADDR_BUS-1:0] lat_addr;
  logic [REG_DATA_BUS-1:0] lat_wdata;
  logic [MEM_MASK_BUS-1:0] lat_wmask;
  logic [7:0]              tmo_cnt, tmo_next;
  logic                    accept, resp_hit, tmo_hit;
  logic [REG_DATA_BUS-1:0] resp_data;
  logic                    ifu_rvalid_q, lsu_rvalid_q, err_q;
  logic [REG_DATA_BUS-1:0] ifu_rdata_q, lsu_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner;

  arb_pick u_pick (
    .ifu_req    (ifu_req_i),
    .lsu_req    (lsu_req_i),
    .last_owner (last_owner),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_owner <= ARB_OWNER_IFU;
    else if (accept) last_owner <= owner;
  end
`else
  arb_pick u_pick (
    .ifu_req (ifu_req_i),
    .lsu_req (lsu_req_i),
    .any_req (any_req),
    .winner  (winner)
  );
`endif

  assign accept    = (state == ARB_REQ) && mem_ready_i;
  assign resp_hit  = (state == ARB_RESP) && mem_rvalid_i;
  assign tmo_next  = sat_inc(tmo_cnt);
  assign tmo_hit   = (state == ARB_RESP) && !mem_rvalid_i && (tmo_next == TMO_LIMIT);
  assign resp_data = resp_hit ? mem_rdata_i : ZERO_WORD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (any_req) next_state = ARB_REQ;
      ARB_REQ:  if (mem_ready_i) next_state = ARB_RESP;
      ARB_RESP: if (resp_hit || tmo_hit) next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // IFU transactions are latched as plain reads regardless of LSU-side inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner        <= ARB_OWNER_IFU;
      lat_we       <= 1'b0;
      lat_addr     <= ZERO_ADDR;
      lat_wdata    <= ZERO_WORD;
      lat_wmask    <= ZERO_MASK;
      tmo_cnt      <= 8'd0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      ifu_rdata_q  <= ZERO_WORD;
      lsu_rdata_q  <= ZERO_WORD;
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      if ((state == ARB_IDLE) && any_req) begin
        owner <= winner;
        if (winner == ARB_OWNER_LSU) begin
          lat_we    <= lsu_we_i;
          lat_addr  <= lsu_addr_i;
          lat_wdata <= lsu_wdata_i;
          lat_wmask <= lsu_wmask_i;
        end else begin
          lat_we    <= 1'b0;
          lat_addr  <= ifu_addr_i;
          lat_wdata <= ZERO_WORD;
          lat_wmask <= ZERO_MASK;
        end
      end
      if (accept)
        tmo_cnt <= 8'd0;
      else if ((state == ARB_RESP) && !mem_rvalid_i)
        tmo_cnt <= tmo_next;
      if (resp_hit || tmo_hit) begin
        err_q <= tmo_hit;
        if (owner == ARB_OWNER_LSU) begin
          lsu_rvalid_q <= 1'b1;
          lsu_rdata_q  <= resp_data;
        end else begin
          ifu_rvalid_q <= 1'b1;
          ifu_rdata_q  <= resp_data;
        end
      end
    end
  end

  assign ifu_gnt_o    = accept && (owner == ARB_OWNER_IFU);
  assign lsu_gnt_o    = accept && (owner == ARB_OWNER_LSU);
  assign mem_valid_o  = (state == ARB_REQ);
  assign mem_we_o     = lat_we;
  assign mem_addr_o   = lat_addr;
  assign mem_wdata_o  = lat_wdata;
  assign mem_wmask_o  = lat_wmask;
  assign busy_o       = (state != ARB_IDLE);
  assign err_o        = err_q;
  assign ifu_rvalid_o = ifu_rvalid_q;
  assign ifu_rdata_o  = ifu_rdata_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued as the memory side is driven
// and checked when an rvalid appears; tie order follows the ARB_ROUND_ROBIN_EN build option.
module tb_mem_arbiter;

  localparam int TMO = 4;

  typedef struct {
    logic        is_lsu;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_i, lsu_req_i, lsu_we_i, mem_ready_i, mem_rvalid_i;
  logic [31:0] ifu_addr_i, lsu_addr_i, lsu_wdata_i, mem_rdata_i;
  logic [7:0]  lsu_wmask_i;
  logic        ifu_gnt_o, ifu_rvalid_o, lsu_gnt_o, lsu_rvalid_o;
  logic        mem_valid_o, mem_we_o, busy_o, err_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.RESP_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_i    (ifu_req_i),
    .ifu_addr_i   (ifu_addr_i),
    .ifu_gnt_o    (ifu_gnt_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .ifu_rdata_o  (ifu_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_wmask_i  (lsu_wmask_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (ifu_rvalid_o || lsu_rvalid_o)) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rvalid", {ifu_rvalid_o, lsu_rvalid_o}, 2'b00);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("resp_owner", {ifu_rvalid_o, lsu_rvalid_o}, e.is_lsu ? 2'b01 : 2'b10);
        checkOutput("resp_data", e.is_lsu ? lsu_rdata_o : ifu_rdata_o, e.data);
        checkOutput("resp_err", err_o, e.err);
      end
    end else if (rst && err_o) begin
      checkOutput("stray_err", err_o, 1'b0);
    end
  end

  // Serves one transaction starting from an IDLE cycle with requests already driven.
  task automatic applyStimulus(input bit exp_lsu, input int ready_wait, input int resp_wait,
                               input bit timeout, input logic [31:0] rdata, input bit rereq);
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    logic [7:0]  exp_wmask;
    exp_addr  = exp_lsu ? lsu_addr_i : ifu_addr_i;
    exp_we    = exp_lsu ? lsu_we_i : 1'b0;
    exp_wdata = exp_lsu ? lsu_wdata_i : 32'h0;
    exp_wmask = exp_lsu ? lsu_wmask_i : 8'h0;
    nextCycle();
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", mem_valid_o, 1'b1);
      checkOutput("stall_addr", mem_addr_o, exp_addr);
      checkOutput("stall_gnt", {ifu_gnt_o, lsu_gnt_o}, 2'b00);
      nextCycle();
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("mem_valid", mem_valid_o, 1'b1);
    checkOutput("mem_addr", mem_addr_o, exp_addr);
    checkOutput("mem_we", mem_we_o, exp_we);
    checkOutput("mem_wdata", mem_wdata_o, exp_wdata);
    checkOutput("mem_wmask", mem_wmask_o, exp_wmask);
    checkOutput("gnt", {ifu_gnt_o, lsu_gnt_o}, exp_lsu ? 2'b01 : 2'b10);
    nextCycle();
    mem_ready_i = 1'b0;
    if (!rereq) begin
      if (exp_lsu) lsu_req_i = 1'b0;
      else         ifu_req_i = 1'b0;
    end
    @(negedge clk);
    checkOutput("resp_state", {busy_o, mem_valid_o, ifu_gnt_o, lsu_gnt_o}, 4'b1000);
    #1;
    if (timeout) begin
      sb_q.push_back('{exp_lsu, 32'h0, 1'b1});
      repeat (TMO) nextCycle();
    end else begin
      repeat (resp_wait) nextCycle();
      sb_q.push_back('{exp_lsu, rdata, 1'b0});
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      nextCycle();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    #1;
    checkOutput("idle_busy", busy_o, 1'b0);
    checkOutput("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_i = 0; lsu_req_i = 0; lsu_we_i = 0; mem_ready_i = 0; mem_rvalid_i = 0;
    ifu_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; mem_rdata_i = 0; lsu_wmask_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", {busy_o, mem_valid_o, mem_we_o, ifu_gnt_o, lsu_gnt_o,
                               ifu_rvalid_o, lsu_rvalid_o, err_o}, 8'h00);
    checkOutput("reset_data", {mem_addr_o, mem_wdata_o}, 64'h0);
    nextCycle();
    rst = 1'b1;

    // IFU-only read
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0000;
    applyStimulus(1'b0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    checkOutput("lsu_quiet", {lsu_rvalid_o, lsu_rdata_o}, 33'h0);

    // LSU store
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0102;
    lsu_wdata_i = 32'h0000_00AB; lsu_wmask_i = 8'h04;
    applyStimulus(1'b1, 0, 2, 1'b0, 32'h0000_0001, 1'b0);

    // IFU read with memory stalling the address phase for 5 cycles
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0010;
    applyStimulus(1'b0, 5, 1, 1'b0, 32'h1357_9BDF, 1'b0);

    // Two ties in a row, then the remaining requester alone
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0400;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0300;
    lsu_wdata_i = 32'h0; lsu_wmask_i = 8'h0F;
`ifdef ARB_ROUND_ROBIN_EN
    applyStimulus(1'b1, 0, 0, 1'b0, 32'hA1A1_0001, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'hB2B2_0002, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 32'hC3C3_0003, 1'b0);
`else
    applyStimulus(1'b1, 0, 0, 1'b0, 32'hA1A1_0001, 1'b1);
    applyStimulus(1'b1, 0, 0, 1'b0, 32'hB2B2_0002, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'hC3C3_0003, 1'b0);
`endif

    // IFU read with no response beat: timeout forces zero data and err
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0020;
    applyStimulus(1'b0, 0, 0, 1'b1, 32'h0, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("err_single", err_o, 1'b0);
    #1;

    // Reset in the middle of RESP
    ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0200;
    nextCycle();
    mem_ready_i = 1'b1;
    nextCycle();
    mem_ready_i = 1'b0; ifu_req_i = 1'b0;
    nextCycle();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {busy_o, mem_valid_o, mem_we_o, ifu_rvalid_o, lsu_rvalid_o, err_o}, 6'h00);
    checkOutput("midrst_addr", mem_addr_o, 32'h0);
    checkOutput("midrst_rdata", {ifu_rdata_o, lsu_rdata_o}, 64'h0);
    nextCycle();
    rst = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEED_FACE;
    nextCycle();
    mem_rvalid_i = 1'b0;
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("postrst_idle", {busy_o, ifu_rvalid_o, lsu_rvalid_o}, 3'b000);
    #1;

    // Normal LSU load after reset
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0500;
    lsu_wdata_i = 32'h0; lsu_wmask_i = 8'hFF;
    applyStimulus(1'b1, 1, 1, 1'b0, 32'h1234_5678, 1'b0);

    repeat (2) nextCycle();
    checkOutput("final_queue", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the NPC's single data/instruction memory port between the instruction fetch unit (IFU) and the load/store path fed by the execute stage. It accepts one outstanding transaction at a time. Each transaction is registered and presented on a valid/ready address phase, then the arbiter waits for a single response beat and routes it back to the owner. It sits between the IFU/execute stages and the memory model, and provides the stall source (`busy_o`) for the pipeline.

## Interface
- `RESP_TIMEOUT`, 255: cycles to wait in RESP for `mem_rvalid_i` before forcing an error response; must be 1..255.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `ifu_req_i` in 1: fetch request; held with address until `ifu_gnt_o`.
- `ifu_addr_i` in 32 (`MEM_ADDR_BUS`): fetch address.
- `ifu_gnt_o` out 1: address-phase accept pulse.
- `ifu_rvalid_o` out 1: response pulse.
- `ifu_rdata_o` out 32: response data.
- `lsu_req_i` in 1: load/store request; held with all fields until `lsu_gnt_o`.
- `lsu_we_i` in 1: 1 = store.
- `lsu_addr_i` in 32: access address (execute `rmem_addr_o`/`wmem_addr_o`).
- `lsu_wdata_i` in 32: store data.
- `lsu_wmask_i` in 8 (`MEM_MASK_BUS`): byte mask.
- `lsu_gnt_o` out 1: accept pulse.
- `lsu_rvalid_o` out 1: response pulse (also for stores).
- `lsu_rdata_o` out 32: load data.
- `mem_valid_o` out 1: address phase valid.
- `mem_ready_i` in 1: memory accepts.
- `mem_we_o` out 1: write enable.
- `mem_addr_o` out 32: address.
- `mem_wdata_o` out 32: write data.
- `mem_wmask_o` out 8: byte mask.
- `mem_rvalid_i` in 1: response beat.
- `mem_rdata_i` in 32: response data.
- `busy_o` out 1: state ≠ IDLE.
- `err_o` out 1: one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**:
  - If any request is present, pick a winner.
  - Latch the winner's addr/we/wdata/wmask (IFU: we=0, wmask=0, wdata=0) and the owner id.
  - Go to REQ. With no request, stay in IDLE.
- **REQ**:
  - `mem_valid_o`=1, `mem_*` driven from the latched registers and stable until accepted.
  - On `mem_ready_i`=1: owner's gnt=1 in the same cycle (combinational), clear the timeout counter, go to RESP.
- **RESP**:
  - On `mem_rvalid_i`=1: register `mem_rdata_i` into the owner's rdata, owner's rvalid=1 next cycle, go to IDLE.
  - Otherwise increment the timeout counter. When it equals `RESP_TIMEOUT`: owner rvalid=1 and rdata=0 next cycle, `err_o`=1 for that cycle, go to IDLE.
- Inputs are ignored outside their state: `mem_ready_i` outside REQ, `mem_rvalid_i` outside RESP.
- The non-owner's gnt/rvalid stay 0 throughout.
- A requester dropping req before gnt is illegal; the latched transaction still completes.
- Fixed priority (default build): LSU beats IFU when both requests are present.
- Reset: state=IDLE, latched fields=0, counter=0, owner=IFU, last-owner=IFU. All outputs are 0.
- Reset mid-transaction aborts the transaction silently; no rvalid is generated.

## Timing
- Request sampled at edge 0 → REQ in cycle 1 → gnt in cycle 1 if ready → RESP in cycle 2 → rvalid_i in cycle 2 → owner rvalid/rdata in cycle 3, state IDLE in cycle 3.
- Minimum request-to-response latency: 3 cycles.
- Back-to-back throughput: one transaction per 3 cycles at best (REQ, RESP, IDLE).
- rvalid/rdata/err are registered outputs. gnt and `mem_valid_o` are decoded from state and registers.
- The timeout counter is 8 bits and saturates; it never wraps.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, the requester that was not the last owner wins. Last-owner is updated at each grant.
- Undefined: fixed LSU-over-IFU priority; the last-owner register is not built.
- Single-requester behaviour is identical in both builds.

## Structure
- `defines.v` gains:
  - state encodings `ARB_IDLE`/`ARB_REQ`/`ARB_RESP`
  - owner ids `ARB_OWNER_IFU`/`ARB_OWNER_LSU`
- Reuse the existing `MEM_ADDR_BUS`, `MEM_MASK_BUS`, `REG_DATA_BUS`, `ZERO_ADDR`, `ZERO_WORD`, `ZERO_MASK`.
- One natural sub-module: `arb_pick`, a combinational winner selection containing the round-robin logic under the macro.

## Test plan
- IFU-only read of 0x8000_0000, memory ready immediately, rvalid next cycle with 0xDEADBEEF → `ifu_gnt_o` in cycle 1, `ifu_rdata_o`=0xDEADBEEF with `ifu_rvalid_o` in cycle 3, `lsu_*` outputs stay 0.
- LSU store to addr 0x8000_0102, wdata 0x0000_00AB, mask 0x04 → `mem_we_o`=1, `mem_addr_o`=0x8000_0102, `mem_wmask_o`=0x04; `lsu_rvalid_o` pulses after `mem_rvalid_i`.
- Both requests in the same cycle, issued twice in a row:
  - default build → LSU granted both times;
  - `ARB_ROUND_ROBIN_EN` build → LSU then IFU.
- `mem_ready_i` held 0 for 5 cycles in REQ → `mem_valid_o` and the address stay stable all 5 cycles; gnt appears only in the cycle ready=1.
- `RESP_TIMEOUT`=4, no `mem_rvalid_i` → owner rvalid=1, rdata=0, `err_o`=1 exactly once; state returns to IDLE.
- `rst` pulled to 0 during RESP → all outputs 0 immediately (asynchronous); no rvalid after release; the next request completes normally.
